tcam_ctrl: RTL and testbench
============================

// Module: tcam_ctrl
// PURPOSE
//  Command sequencer directly upstream of tcam. Accepts SEARCH/READ/WRITE/CLEAR commands over valid/ready,
//  drives one tcam_req_t per operation and registers the combinational tcam_resp_t.
//  Returns one response per command over valid/ready. CLEAR walks every entry and invalidates it.
//  Decouples the datapath client from tcam's combinational lookup timing.
// PARAMETERS
//  KEY_WIDTH   `KEY_WIDTH   key/mask width in bits (matches cam_key_t)
//  KEY_DEPTH   `KEY_DEPTH   number of tcam entries
//  ADDR_WIDTH  $clog2(KEY_DEPTH)   entry index width (matches cam_addr_t)
// PORTS
//  clk        in   1           clock
//  rst        in   1           asynchronous reset, active-high
//  cmd_valid  in   1           command present
//  cmd_ready  out  1           command accepted when cmd_valid&cmd_ready at posedge
//  cmd_op     in   2           0=SEARCH 1=READ 2=WRITE 3=CLEAR
//  cmd_addr   in   ADDR_WIDTH  entry index (READ/WRITE)
//  cmd_data   in   KEY_WIDTH   key (SEARCH/WRITE)
//  cmd_dvld   in   1           WRITE: entry valid bit to store
//  cmd_mask   in   KEY_WIDTH   SEARCH compare mask (1 = bit compared)
//  rsp_valid  out  1           response present
//  rsp_ready  in   1           response consumed when rsp_valid&rsp_ready at posedge
//  rsp_op     out  2           op of the command this response belongs to
//  rsp_hit    out  1           SEARCH: any entry matched; else 0
//  rsp_addr   out  ADDR_WIDTH  SEARCH: matching index; READ/WRITE: cmd_addr; CLEAR: 0
//  rsp_data   out  KEY_WIDTH   READ: stored key; else 0
//  busy       out  1           state != IDLE
//  tcam_req   out  tcam_req_t  request to tcam
//  tcam_resp  in   tcam_resp_t combinational result from tcam
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, rsp_valid=0, rsp_* fields=0, busy=0.
//    tcam_req all-zero (addr_vld=0, we=0). Clear counter=0. Command register cleared.
//  - cmd_ready = (state==IDLE); never depends combinationally on cmd_valid.
//    Accepted command is latched into a command register.
//  - FSM IDLE -> EXEC: on accept with op!=CLEAR. IDLE -> CLR: on accept with op==CLEAR.
//  - EXEC (exactly 1 cycle); tcam_req is driven from the command register:
//    - SEARCH: addr_vld=0, we=0, data=key, mask=cmd_mask.
//    - READ: addr_vld=1, we=0, addr=cmd_addr.
//    - WRITE: addr_vld=1, we=1, addr, data=key, data_vld=cmd_dvld, mask=0.
//    - At end of cycle, rsp_* are registered: hit=tcam_resp.addr_vld, addr=tcam_resp.addr (SEARCH),
//      data=tcam_resp.data (READ). Next state RSP.
//  - CLR: each cycle drives addr_vld=1, we=1, data=0, data_vld=0, addr=counter, then counter++.
//    After addr KEY_DEPTH-1 is written -> RSP; counter back to 0. Lasts exactly KEY_DEPTH cycles.
//  - RSP: rsp_valid=1, rsp_* held stable until rsp_ready. On handshake -> IDLE.
//    No new command is accepted in the handshake cycle itself.
//  - Latency: command accepted at edge N -> tcam driven cycle N+1 -> rsp_valid from edge N+2.
//    CLEAR: rsp_valid from edge N+1+KEY_DEPTH.
//  - Outside EXEC/CLR, tcam_req is all-zero: no spurious writes, no reads.
//  - Ordering: strictly one command in flight, so a WRITE is visible to any later SEARCH/READ.
//  - Writes land at the tcam posedge ending the EXEC/CLR cycle.
//  - cmd_addr >= KEY_DEPTH (non-power-of-2 depth): WRITE/READ are dropped (tcam_req idle),
//    response still returned with rsp_data=0.
//  - Reset during CLR or RSP: aborts. Entries already cleared stay cleared. No response is issued.
// TESTING
//  1. WRITE addr=3 key=0xA5 dvld=1; SEARCH key=0xA5 mask=all-ones -> rsp_hit=1, rsp_addr=3,
//     rsp_valid at accept+2 cycles.
//  2. SEARCH key=0x5A mask=all-ones on tcam holding only 0xA5 -> rsp_hit=0.
//     Then SEARCH key=0xA0 mask=0xF0 -> rsp_hit=1, rsp_addr=3.
//  3. READ addr=3 after test 1 -> rsp_data=0xA5, rsp_op=1, rsp_hit=0.
//  4. Fill 4 entries, CLEAR -> busy high exactly KEY_DEPTH+1 cycles before rsp_valid.
//     Subsequent SEARCH of each key -> rsp_hit=0.
//  5. Hold rsp_ready=0 for 10 cycles with cmd_valid=1 -> cmd_ready=0, rsp_* stable throughout.
//     rsp_ready=1 -> next command accepted the cycle after the handshake.
//  6. Assert rst at clear counter=2 -> outputs zero immediately, no rsp_valid.
//     Entries 0,1 invalid, entry 5 still hits.

Source files
------------

// File: rtl/tcam_ctrl_if.sv
// Shared TCAM types and the client-facing command/response interface of tcam_ctrl.
// The package comes first so that the interface, the controller and the bench all see one set of types.
package tcam_pkg;
  localparam int TCAM_KEY_WIDTH  = 8;
  localparam int TCAM_KEY_DEPTH  = 6;
  localparam int TCAM_ADDR_WIDTH = $clog2(TCAM_KEY_DEPTH);

  typedef logic [TCAM_KEY_WIDTH-1:0]  cam_key_t;
  typedef logic [TCAM_ADDR_WIDTH-1:0] cam_addr_t;

  typedef enum logic [1:0] {
    OP_SEARCH = 2'd0,
    OP_READ   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_CLEAR  = 2'd3
  } cmd_op_e;

  typedef struct packed {
    logic      addr_vld;
    logic      we;
    cam_addr_t addr;
    cam_key_t  data;
    logic      data_vld;
    cam_key_t  mask;
  } tcam_req_t;

  typedef struct packed {
    logic      addr_vld;
    cam_addr_t addr;
    cam_key_t  data;
  } tcam_resp_t;

  typedef struct packed {
    cmd_op_e   op;
    cam_addr_t addr;
    cam_key_t  data;
    logic      dvld;
    cam_key_t  mask;
  } cmd_t;

  typedef struct packed {
    cmd_op_e   op;
    logic      hit;
    cam_addr_t addr;
    cam_key_t  data;
  } rsp_t;
endpackage

interface tcam_ctrl_if;
  import tcam_pkg::*;

  logic      cmd_valid;
  logic      cmd_ready;
  logic [1:0] cmd_op;
  cam_addr_t cmd_addr;
  cam_key_t  cmd_data;
  logic      cmd_dvld;
  cam_key_t  cmd_mask;

  logic      rsp_valid;
  logic      rsp_ready;
  logic [1:0] rsp_op;
  logic      rsp_hit;
  cam_addr_t rsp_addr;
  cam_key_t  rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_dvld, cmd_mask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_addr, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_dvld, cmd_mask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_op, rsp_hit, rsp_addr, rsp_data
  );
endinterface

// File: rtl/tcam_ctrl.sv
// Command sequencer in front of a combinational TCAM: one command in flight, one registered
// response per command, and a CLEAR that walks and invalidates every entry.
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int KEY_WIDTH  = TCAM_KEY_WIDTH,
  parameter int KEY_DEPTH  = TCAM_KEY_DEPTH,
  parameter int ADDR_WIDTH = $clog2(KEY_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  tcam_ctrl_if.slave       bus,
  output logic             busy,
  output tcam_req_t        tcam_req,
  input  tcam_resp_t       tcam_resp
);

  typedef enum logic [1:0] {IDLE, EXEC, CLR, RSP} state_e;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(KEY_DEPTH - 1);

  state_e                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  rsp_t                  rsp_q, rsp_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [KEY_WIDTH-1:0]  rd_data;
  logic                  addr_ok;

  // Non-power-of-2 depths leave unused index codes; READ/WRITE to them never reach the TCAM.
  assign addr_ok = int'(cmd_q.addr) < KEY_DEPTH;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      rsp_q     <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      rsp_q     <= rsp_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every signal written in an always_comb gets a default first; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    clr_cnt_d = clr_cnt_q;
    rd_data   = (cmd_q.op == OP_READ && addr_ok) ? tcam_resp.data : '0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_d   = '{op:   cmd_op_e'(bus.cmd_op), addr: bus.cmd_addr, data: bus.cmd_data,
                      dvld: bus.cmd_dvld,          mask: bus.cmd_mask};
          state_d = (cmd_op_e'(bus.cmd_op) == OP_CLEAR) ? CLR : EXEC;
        end
      end
      EXEC: begin
        rsp_d.op   = cmd_q.op;
        rsp_d.hit  = (cmd_q.op == OP_SEARCH) && tcam_resp.addr_vld;
        rsp_d.addr = (cmd_q.op == OP_SEARCH) ? tcam_resp.addr : cmd_q.addr;
        rsp_d.data = rd_data;
        state_d    = RSP;
      end
      CLR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
          rsp_d     = '{op: OP_CLEAR, hit: 1'b0, addr: '0, data: '0};
          state_d   = RSP;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        end
      end
      RSP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tcam_req      = '0;
    bus.cmd_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RSP);
    busy          = (state_q != IDLE);
    bus.rsp_op    = rsp_q.op;
    bus.rsp_hit   = rsp_q.hit;
    bus.rsp_addr  = rsp_q.addr;
    bus.rsp_data  = rsp_q.data;
    if (state_q == EXEC) begin
      unique case (cmd_q.op)
        OP_SEARCH: begin
          tcam_req.data = cmd_q.data;
          tcam_req.mask = cmd_q.mask;
        end
        OP_READ: begin
          tcam_req.addr_vld = addr_ok;
          tcam_req.addr     = addr_ok ? cmd_q.addr : '0;
        end
        OP_WRITE: begin
          if (addr_ok) begin
            tcam_req.addr_vld = 1'b1;
            tcam_req.we       = 1'b1;
            tcam_req.addr     = cmd_q.addr;
            tcam_req.data     = cmd_q.data;
            tcam_req.data_vld = cmd_q.dvld;
          end
        end
        default: ;
      endcase
    end else if (state_q == CLR) begin
      tcam_req.addr_vld = 1'b1;
      tcam_req.we       = 1'b1;
      tcam_req.addr     = clr_cnt_q;
    end
  end

endmodule

// File: tb/tb_tcam_ctrl.sv
// Self-checking bench for tcam_ctrl: behavioural TCAM model, table of commands with
// expected responses pushed to a scoreboard, plus hand-written backpressure and reset-abort sequences.
module tb_tcam_ctrl;
  import tcam_pkg::*;

  localparam int D = TCAM_KEY_DEPTH;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  tcam_req_t  tcam_req;
  tcam_resp_t tcam_resp;

  tcam_ctrl_if bus ();

  tcam_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .tcam_req  (tcam_req),
    .tcam_resp (tcam_resp)
  );

  always #5 clk = ~clk;

  // Behavioural TCAM: lowest matching valid index wins; a miss reports address 0.
  cam_key_t key_m [D] = '{default: '0};
  logic     vld_m [D] = '{default: 1'b0};

  always_comb begin
    tcam_resp = '0;
    if (tcam_req.addr_vld) begin
      if (int'(tcam_req.addr) < D) tcam_resp.data = key_m[tcam_req.addr];
    end else begin
      for (int i = D - 1; i >= 0; i--) begin
        if (vld_m[i] && (((key_m[i] ^ tcam_req.data) & tcam_req.mask) == '0)) begin
          tcam_resp.addr_vld = 1'b1;
          tcam_resp.addr     = cam_addr_t'(i);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (tcam_req.addr_vld && tcam_req.we && int'(tcam_req.addr) < D) begin
      key_m[tcam_req.addr] <= tcam_req.data;
      vld_m[tcam_req.addr] <= tcam_req.data_vld;
    end
  end

  typedef struct {
    logic [1:0] op;
    cam_addr_t  addr;
    cam_key_t   data;
    logic       dvld;
    cam_key_t   mask;
    logic       exp_hit;
    cam_addr_t  exp_addr;
    cam_key_t   exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic       hit;
    cam_addr_t  addr;
    cam_key_t   data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input int addr, input int data, input logic dvld,
                              input int mask, input logic hit, input int eaddr, input int edata);
    vec_t v;
    v.op = op;  v.addr = cam_addr_t'(addr);  v.data = cam_key_t'(data);
    v.dvld = dvld;  v.mask = cam_key_t'(mask);
    v.exp_hit = hit;  v.exp_addr = cam_addr_t'(eaddr);  v.exp_data = cam_key_t'(edata);
    return v;
  endfunction

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.op = v.op;  e.hit = v.exp_hit;  e.addr = v.exp_addr;  e.data = v.exp_data;
    return e;
  endfunction

  task automatic drive(input vec_t v);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = v.op;
    bus.cmd_addr  = v.addr;
    bus.cmd_data  = v.data;
    bus.cmd_dvld  = v.dvld;
    bus.cmd_mask  = v.mask;
  endtask

  // Called just after a negedge; returns at the negedge following the accepting posedge.
  task automatic issue(input vec_t v);
    int n = 0;
    drive(v);
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) check("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    else sb.push_back(to_exp(v));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic compare_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_op"},   32'(bus.rsp_op),   32'(e.op));
      check({tag, "_hit"},  32'(bus.rsp_hit),  32'(e.hit));
      check({tag, "_addr"}, 32'(bus.rsp_addr), 32'(e.addr));
      check({tag, "_data"}, 32'(bus.rsp_data), 32'(e.data));
    end
  endtask

  // Entry point is the first negedge after acceptance (lat=1).
  task automatic collect(input int exp_lat, input bit chk_busy, input string tag);
    int lat = 1;
    int bc  = int'(busy);
    while (!bus.rsp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      bc += int'(busy);
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_busy) check({tag, "_busy_cycles"}, 32'(bc), 32'(D + 1));
    compare_rsp(tag);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_release"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_req_idle"}, 32'(tcam_req), 32'd0);
  endtask

  task automatic run(input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    issue(tbl[idx]);
    collect((tbl[idx].op == 2'd3) ? D + 1 : 2, tbl[idx].op == 2'd3, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   stable;
    int   n;
    exp_t snap;

    //            op   addr data dvld mask   hit eaddr edata
    tbl.push_back(mk(2'd2, 3, 'hA5, 1, 'h00, 0, 3, 'h00));  // 0  write entry 3
    tbl.push_back(mk(2'd0, 0, 'hA5, 0, 'hFF, 1, 3, 'h00));  // 1  exact hit
    tbl.push_back(mk(2'd0, 0, 'h5A, 0, 'hFF, 0, 0, 'h00));  // 2  miss
    tbl.push_back(mk(2'd0, 0, 'hA0, 0, 'hF0, 1, 3, 'h00));  // 3  masked hit
    tbl.push_back(mk(2'd1, 3, 'h00, 0, 'h00, 0, 3, 'hA5));  // 4  read back
    tbl.push_back(mk(2'd2, 7, 'h3C, 1, 'h00, 0, 7, 'h00));  // 5  out-of-range write
    tbl.push_back(mk(2'd1, 7, 'h00, 0, 'h00, 0, 7, 'h00));  // 6  out-of-range read
    tbl.push_back(mk(2'd0, 0, 'h3C, 0, 'hFF, 0, 0, 'h00));  // 7  dropped write not visible
    tbl.push_back(mk(2'd2, 0, 'h11, 1, 'h00, 0, 0, 'h00));  // 8
    tbl.push_back(mk(2'd2, 1, 'h22, 1, 'h00, 0, 1, 'h00));  // 9
    tbl.push_back(mk(2'd2, 2, 'h33, 1, 'h00, 0, 2, 'h00));  // 10
    tbl.push_back(mk(2'd2, 5, 'h44, 1, 'h00, 0, 5, 'h00));  // 11
    tbl.push_back(mk(2'd3, 0, 'h00, 0, 'h00, 0, 0, 'h00));  // 12 clear all
    tbl.push_back(mk(2'd0, 0, 'h11, 0, 'hFF, 0, 0, 'h00));  // 13
    tbl.push_back(mk(2'd0, 0, 'h22, 0, 'hFF, 0, 0, 'h00));  // 14
    tbl.push_back(mk(2'd0, 0, 'h33, 0, 'hFF, 0, 0, 'h00));  // 15
    tbl.push_back(mk(2'd0, 0, 'h44, 0, 'hFF, 0, 0, 'h00));  // 16
    tbl.push_back(mk(2'd0, 0, 'hA5, 0, 'hFF, 0, 0, 'h00));  // 17
    tbl.push_back(mk(2'd2, 5, 'h44, 1, 'h00, 0, 5, 'h00));  // 18
    tbl.push_back(mk(2'd0, 0, 'h44, 0, 'hFF, 1, 5, 'h00));  // 19 held response
    tbl.push_back(mk(2'd1, 5, 'h00, 0, 'h00, 0, 5, 'h44));  // 20 queued behind it
    tbl.push_back(mk(2'd2, 0, 'h11, 1, 'h00, 0, 0, 'h00));  // 21
    tbl.push_back(mk(2'd2, 1, 'h22, 1, 'h00, 0, 1, 'h00));  // 22
    tbl.push_back(mk(2'd2, 2, 'h33, 1, 'h00, 0, 2, 'h00));  // 23
    tbl.push_back(mk(2'd0, 0, 'h11, 0, 'hFF, 0, 0, 'h00));  // 24 cleared before abort
    tbl.push_back(mk(2'd0, 0, 'h22, 0, 'hFF, 0, 0, 'h00));  // 25 cleared before abort
    tbl.push_back(mk(2'd0, 0, 'h33, 0, 'hFF, 1, 2, 'h00));  // 26 survived abort
    tbl.push_back(mk(2'd0, 0, 'h44, 0, 'hFF, 1, 5, 'h00));  // 27 survived abort

    rst = 1'b1;
    bus.cmd_valid = 1'b0;  bus.cmd_op = '0;  bus.cmd_addr = '0;
    bus.cmd_data  = '0;    bus.cmd_dvld = 1'b0;  bus.cmd_mask = '0;
    bus.rsp_ready = 1'b0;
    #2;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy",      32'(busy),          32'd0);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_req",       32'(tcam_req),      32'd0);
    check("rst_rsp_fields", 32'({bus.rsp_op, bus.rsp_hit, bus.rsp_addr, bus.rsp_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i <= 18; i++) run(i);

    // Response backpressure with a second command waiting.
    issue(tbl[19]);
    drive(tbl[20]);
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_lat", 32'(n), 32'd2);
    snap.op = bus.rsp_op;  snap.hit = bus.rsp_hit;  snap.addr = bus.rsp_addr;  snap.data = bus.rsp_data;
    compare_rsp("t5_search");
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("t5_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
      if (!bus.rsp_valid || bus.rsp_op !== snap.op || bus.rsp_hit !== snap.hit ||
          bus.rsp_addr !== snap.addr || bus.rsp_data !== snap.data || tcam_req !== '0)
        stable = 1'b0;
      @(negedge clk);
    end
    check("t5_stable", 32'(stable), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("t5_ready_after_hs", 32'(bus.cmd_ready), 32'd1);
    check("t5_rsp_dropped",    32'(bus.rsp_valid), 32'd0);
    sb.push_back(to_exp(tbl[20]));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("t5_accepted_busy",  32'(busy),          32'd1);
    check("t5_accepted_ready", 32'(bus.cmd_ready), 32'd0);
    collect(2, 1'b0, "t5_read");

    for (int i = 21; i <= 23; i++) run(i);

    // Reset while the clear walk is at entry 2.
    issue(mk(2'd3, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    check("t6_cnt_addr", 32'(tcam_req.addr), 32'd2);
    check("t6_cnt_we",   32'(tcam_req.we),   32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_busy",       32'(busy),          32'd0);
    check("t6_rsp_valid",  32'(bus.rsp_valid), 32'd0);
    check("t6_req",        32'(tcam_req),      32'd0);
    check("t6_rsp_fields", 32'({bus.rsp_op, bus.rsp_hit, bus.rsp_addr, bus.rsp_data}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    stable = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    check("t6_no_response", 32'(stable), 32'd1);

    for (int i = 24; i <= 27; i++) run(i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
